trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Initiator side of the CSR register file's trap interface: detects synchronous exceptions, enabled interrupts and xRET instructions at the execute boundary.
- Drains the pipeline, then presents exception_pending / m_cause / pc_exc / m_ret / s_ret to the CSR register file for exactly one commit cycle.
- Then issues a one-cycle front-end redirect to the epc returned by the register file.

Parameters:
DRAIN_MAX, 15, max cycles waited in DRAIN for flush_ack before forcing commit
XLEN, 32, data/PC width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
instr_valid  in  1  a valid instruction occupies execute this cycle
instr_pc  in  XLEN  PC of that instruction
exc_valid  in  1  execute reports a synchronous exception (qualified by instr_valid)
exc_code  in  5  synchronous exception code
mret_req  in  1  instruction is MRET
sret_req  in  1  instruction is SRET
current_mode  in  2  privilege mode from CSR file (U=0, S=1, M=3)
m_interrupt, s_interrupt, m_timer, s_timer  in  1 each  raw pending lines
m_eie, m_tie, s_eie, s_tie  in  1 each  enables from CSR file (already ANDed with status xIE)
flush_ack  in  1  pipeline reports drained
epc  in  XLEN  trap/return target from CSR file
flush_req  out  1  flush request to pipeline
exception_pending  out  1  commit strobe to CSR file
m_cause  out  XLEN  {interrupt bit, code}
pc_exc  out  XLEN  PC saved into xEPC
m_ret  out  1  MRET in progress
s_ret  out  1  SRET in progress
redirect_valid  out  1  front-end redirect strobe
redirect_pc  out  XLEN  redirect target
drain_timeout  out  1  sticky: a drain timed out

Behaviour:
- Reset: state IDLE, drain counter 0, latched cause/pc/kind 0. All outputs 0: flush_req, exception_pending, m_cause, pc_exc, m_ret, s_ret, redirect_valid, redirect_pc, drain_timeout. Reset asserted mid-operation aborts the sequence immediately; no partial commit.
- Event detection in IDLE only, when instr_valid=1. Priority, highest first:
  1. Interrupt: MEI (m_interrupt&m_eie, code 11) > MTI (m_timer&m_tie, 7) > SEI (s_interrupt&s_eie, 9) > STI (s_timer&s_tie, 5). m_cause = {1'b1, 26'b0, code}.
  2. Synchronous exception: m_cause = {1'b0, 26'b0, exc_code}.
  3. mret_req with current_mode==M: kind MRET. With current_mode!=M: illegal instruction, code 2.
  4. sret_req with current_mode>=S: kind SRET. With current_mode==U: illegal instruction, code 2.
  - pc_exc is latched from instr_pc for every kind. The offending instruction is not retired.
- States:
  - IDLE: on event, latch kind/cause/pc, clear counter → DRAIN.
  - DRAIN: flush_req=1, counter increments each cycle. Exit → COMMIT on flush_ack=1, or when counter==DRAIN_MAX (also sets drain_timeout, sticky until rst).
  - COMMIT: exactly one cycle. exception_pending=1; m_cause and pc_exc driven from latches; m_ret/s_ret=1 for MRET/SRET kinds. flush_req=0 → REDIRECT.
  - REDIRECT: exactly one cycle. redirect_valid=1; redirect_pc=epc (combinational pass-through, since the CSR file updated at the COMMIT edge); m_ret/s_ret held so epc selects xEPC → IDLE.
- Minimum latency from event to redirect_valid: 3 cycles (flush_ack already high in the first DRAIN cycle).
- m_cause/pc_exc hold their latched values outside COMMIT; only exception_pending qualifies them.
- Events outside IDLE are ignored. Level interrupts remain pending and are re-evaluated on return to IDLE. Synchronous exceptions are regenerated by re-execution.
- Interrupt concurrent with exception or xRET: the interrupt wins. The instruction re-executes after return.
- mret_req and sret_req both set: MRET handling applies.
- m_ret and s_ret are never both 1.
- exception_pending is never 1 outside COMMIT, so CSR writebacks from older instructions proceed during DRAIN.

Test Plan:
- Reset then idle: rst pulse mid-DRAIN → all outputs 0 next edge, state IDLE, no exception_pending pulse seen.
- Illegal exception: instr_valid=1, exc_valid=1, exc_code=2, instr_pc=0x100, flush_ack=1 → flush_req at cycle 1; exception_pending=1, m_cause=0x00000002, pc_exc=0x100 at cycle 2; redirect_valid=1, redirect_pc=epc(0x80) at cycle 3.
- Interrupt priority: m_interrupt=m_timer=s_interrupt=1, all enables=1, exc_valid=1 → m_cause=0x8000000B. Repeat with m_eie=0 → 0x80000007.
- MRET in M mode, epc=0x204 → exception_pending=1 and m_ret=1 in COMMIT; m_ret=1, redirect_pc=0x204 in REDIRECT. MRET in U mode → m_cause=0x00000002, m_ret=0.
- Drain timeout: flush_ack held 0 → COMMIT exactly DRAIN_MAX cycles after DRAIN entry, drain_timeout=1 and stays 1 until rst.
- Busy-ignore: second exc_valid during DRAIN/COMMIT → no second commit. Interrupt held high → new sequence starts the cycle after returning to IDLE.

Source files
------------

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
//
// Trap initiator at the execute boundary. Detects enabled interrupts,
// synchronous exceptions and MRET/SRET, drains the pipeline, presents one
// commit cycle to the CSR register file and then issues a one-cycle
// front-end redirect to the epc that the register file returns.
//
// Sequence: IDLE -> DRAIN -> COMMIT (1 cycle) -> REDIRECT (1 cycle) -> IDLE
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   instr_valid, instr_pc instruction in execute and its PC
//   exc_valid, exc_code   synchronous exception report
//   mret_req, sret_req    xRET decode
//   current_mode          privilege mode (U=0, S=1, M=3)
//   m_interrupt, m_timer, s_interrupt, s_timer  raw pending lines
//   m_eie, m_tie, s_eie, s_tie                  qualified enables
//   flush_ack             pipeline drained
//   epc                   trap/return target from the CSR file
//   flush_req             flush request to the pipeline (DRAIN)
//   exception_pending     commit strobe to the CSR file (COMMIT)
//   m_cause, pc_exc       latched cause and faulting PC
//   m_ret, s_ret          xRET in progress (COMMIT and REDIRECT)
//   redirect_valid/pc     front-end redirect (REDIRECT)
//   drain_timeout         sticky: a drain ran out of cycles
// -----------------------------------------------------------------------------
module trap_controller #(
  parameter int DRAIN_MAX = 15,
  parameter int XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] instr_pc,
  input  logic            exc_valid,
  input  logic [4:0]      exc_code,
  input  logic            mret_req,
  input  logic            sret_req,
  input  logic [1:0]      current_mode,
  input  logic            m_interrupt,
  input  logic            s_interrupt,
  input  logic            m_timer,
  input  logic            s_timer,
  input  logic            m_eie,
  input  logic            m_tie,
  input  logic            s_eie,
  input  logic            s_tie,
  input  logic            flush_ack,
  input  logic [XLEN-1:0] epc,
  output logic            flush_req,
  output logic            exception_pending,
  output logic [XLEN-1:0] m_cause,
  output logic [XLEN-1:0] pc_exc,
  output logic            m_ret,
  output logic            s_ret,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            drain_timeout
);

  localparam int CW = $clog2(DRAIN_MAX + 1);

  localparam logic [4:0] CODE_MEI     = 5'd11;
  localparam logic [4:0] CODE_MTI     = 5'd7;
  localparam logic [4:0] CODE_SEI     = 5'd9;
  localparam logic [4:0] CODE_STI     = 5'd5;
  localparam logic [4:0] CODE_ILLEGAL = 5'd2;

  localparam logic [1:0] MODE_U = 2'd0;
  localparam logic [1:0] MODE_M = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    COMMIT,
    REDIRECT
  } state_t;

  typedef enum logic [1:0] {
    KIND_TRAP,
    KIND_MRET,
    KIND_SRET
  } kind_t;

  state_t state, state_next;

  kind_t           kind_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   drain_cnt;
  logic [CW-1:0]   drain_cnt_inc;
  logic            timeout_hit;
  logic            timeout_q;

  // Event detection
  logic            evt;
  kind_t           evt_kind;
  logic            evt_int;
  logic [4:0]      evt_code;
  logic [XLEN-1:0] evt_cause;

  // NOTE: every variable assigned in an always_comb gets a default at the top,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    evt       = 1'b0;
    evt_kind  = KIND_TRAP;
    evt_int   = 1'b0;
    evt_code  = 5'd0;
    evt_cause = '0;
    if (instr_valid) begin
      evt = 1'b1;
      // Interrupts outrank everything; the interrupted instruction simply
      // re-executes after the handler returns.
      if (m_interrupt && m_eie) begin
        evt_int  = 1'b1;
        evt_code = CODE_MEI;
      end else if (m_timer && m_tie) begin
        evt_int  = 1'b1;
        evt_code = CODE_MTI;
      end else if (s_interrupt && s_eie) begin
        evt_int  = 1'b1;
        evt_code = CODE_SEI;
      end else if (s_timer && s_tie) begin
        evt_int  = 1'b1;
        evt_code = CODE_STI;
      end else if (exc_valid) begin
        evt_code = exc_code;
      end else if (mret_req) begin
        // MRET wins when both xRET decodes are set.
        if (current_mode == MODE_M) evt_kind = KIND_MRET;
        else                        evt_code = CODE_ILLEGAL;
      end else if (sret_req) begin
        if (current_mode != MODE_U) evt_kind = KIND_SRET;
        else                        evt_code = CODE_ILLEGAL;
      end else begin
        evt = 1'b0;
      end
    end
    evt_cause[XLEN-1] = evt_int;
    evt_cause[4:0]    = evt_code;
  end

  // drain_cnt counts DRAIN cycles already completed; the incremented value is
  // the count including the current cycle, so the drain lasts DRAIN_MAX cycles.
  assign drain_cnt_inc = drain_cnt + CW'(1);

  // Next-state logic
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:     if (evt) state_next = DRAIN;
      DRAIN: begin
        if (flush_ack) begin
          state_next = COMMIT;
        end else if (drain_cnt_inc == CW'(DRAIN_MAX)) begin
          state_next  = COMMIT;
          timeout_hit = 1'b1;
        end
      end
      COMMIT:   state_next = REDIRECT;
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: the asynchronous reset sits in the sensitivity list so a reset in the
  // middle of a sequence returns to IDLE at once, never mid-commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: sequential state is only ever written with non-blocking assignments
  // so every register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q    <= KIND_TRAP;
      cause_q   <= '0;
      pc_q      <= '0;
      drain_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && evt) begin
        kind_q    <= evt_kind;
        cause_q   <= evt_cause;
        pc_q      <= instr_pc;
        drain_cnt <= '0;
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt_inc;
      end
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end

  // Outputs. m_cause/pc_exc hold their latches permanently; exception_pending
  // is the only qualifier the CSR file looks at.
  assign flush_req         = (state == DRAIN);
  assign exception_pending = (state == COMMIT);
  assign m_cause           = cause_q;
  assign pc_exc            = pc_q;
  // xRET flags stay up through REDIRECT so epc keeps selecting xEPC.
  assign m_ret             = (state == COMMIT || state == REDIRECT) && (kind_q == KIND_MRET);
  assign s_ret             = (state == COMMIT || state == REDIRECT) && (kind_q == KIND_SRET);
  assign redirect_valid    = (state == REDIRECT);
  // epc already reflects the CSR update made at the COMMIT edge.
  assign redirect_pc       = (state == REDIRECT) ? epc : '0;
  assign drain_timeout     = timeout_q;

endmodule

// File: tb/tb_trap_controller.sv
// -----------------------------------------------------------------------------
// tb_trap_controller
//
// Directed bench for trap_controller: a table of single-event vectors applied
// with flush_ack high (3-cycle path), plus hand sequences for drain timeout,
// busy-ignore, held interrupt and reset in the middle of DRAIN.
// -----------------------------------------------------------------------------
module tb_trap_controller;

  localparam int DRAIN_MAX = 15;
  localparam int XLEN      = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic [XLEN-1:0] instr_pc;
  logic            exc_valid;
  logic [4:0]      exc_code;
  logic            mret_req;
  logic            sret_req;
  logic [1:0]      current_mode;
  logic            m_interrupt, s_interrupt, m_timer, s_timer;
  logic            m_eie, m_tie, s_eie, s_tie;
  logic            flush_ack;
  logic [XLEN-1:0] epc;
  logic            flush_req;
  logic            exception_pending;
  logic [XLEN-1:0] m_cause;
  logic [XLEN-1:0] pc_exc;
  logic            m_ret;
  logic            s_ret;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            drain_timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  trap_controller #(.DRAIN_MAX(DRAIN_MAX), .XLEN(XLEN)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_valid       (instr_valid),
    .instr_pc          (instr_pc),
    .exc_valid         (exc_valid),
    .exc_code          (exc_code),
    .mret_req          (mret_req),
    .sret_req          (sret_req),
    .current_mode      (current_mode),
    .m_interrupt       (m_interrupt),
    .s_interrupt       (s_interrupt),
    .m_timer           (m_timer),
    .s_timer           (s_timer),
    .m_eie             (m_eie),
    .m_tie             (m_tie),
    .s_eie             (s_eie),
    .s_tie             (s_tie),
    .flush_ack         (flush_ack),
    .epc               (epc),
    .flush_req         (flush_req),
    .exception_pending (exception_pending),
    .m_cause           (m_cause),
    .pc_exc            (pc_exc),
    .m_ret             (m_ret),
    .s_ret             (s_ret),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .drain_timeout     (drain_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        exc;
    logic [4:0]  code;
    logic        mret;
    logic        sret;
    logic [1:0]  mode;
    logic [3:0]  irq;       // {m_interrupt, m_timer, s_interrupt, s_timer}
    logic [3:0]  en;        // {m_eie, m_tie, s_eie, s_tie}
    logic [31:0] pc;
    logic [31:0] epc;
    logic        exp_evt;
    logic        chk_cause;
    logic [31:0] exp_cause;
    logic        exp_mret;
    logic        exp_sret;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_valid  = 1'b0;
    instr_pc     = '0;
    exc_valid    = 1'b0;
    exc_code     = 5'd0;
    mret_req     = 1'b0;
    sret_req     = 1'b0;
    current_mode = 2'd3;
    {m_interrupt, m_timer, s_interrupt, s_timer} = 4'b0000;
    {m_eie, m_tie, s_eie, s_tie}                 = 4'b0000;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " flush_req"},         32'(flush_req),         32'h0);
    check({tag, " exception_pending"}, 32'(exception_pending), 32'h0);
    check({tag, " m_cause"},           m_cause,                32'h0);
    check({tag, " pc_exc"},            pc_exc,                 32'h0);
    check({tag, " m_ret"},             32'(m_ret),             32'h0);
    check({tag, " s_ret"},             32'(s_ret),             32'h0);
    check({tag, " redirect_valid"},    32'(redirect_valid),    32'h0);
    check({tag, " redirect_pc"},       redirect_pc,            32'h0);
    check({tag, " drain_timeout"},     32'(drain_timeout),     32'h0);
  endtask

  // Caller is 1 time unit after a rising edge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    instr_valid  = v.valid;
    exc_valid    = v.exc;
    exc_code     = v.code;
    mret_req     = v.mret;
    sret_req     = v.sret;
    current_mode = v.mode;
    instr_pc     = v.pc;
    epc          = v.epc;
    flush_ack    = 1'b1;
    {m_interrupt, m_timer, s_interrupt, s_timer} = v.irq;
    {m_eie, m_tie, s_eie, s_tie}                 = v.en;
    step();
    clear_inputs();
    if (!v.exp_evt) begin
      check({t, " idle flush_req"}, 32'(flush_req),         32'h0);
      check({t, " idle pending"},   32'(exception_pending), 32'h0);
      return;
    end
    check({t, " drain flush_req"}, 32'(flush_req),         32'h1);
    check({t, " drain pending"},   32'(exception_pending), 32'h0);
    step();
    check({t, " commit pending"},   32'(exception_pending), 32'h1);
    check({t, " commit flush_req"}, 32'(flush_req),         32'h0);
    if (v.chk_cause) check({t, " commit m_cause"}, m_cause, v.exp_cause);
    check({t, " commit pc_exc"}, pc_exc,      v.pc);
    check({t, " commit m_ret"},  32'(m_ret), 32'(v.exp_mret));
    check({t, " commit s_ret"},  32'(s_ret), 32'(v.exp_sret));
    step();
    check({t, " redir valid"},   32'(redirect_valid),    32'h1);
    check({t, " redir pc"},      redirect_pc,            v.epc);
    check({t, " redir pending"}, 32'(exception_pending), 32'h0);
    check({t, " redir m_ret"},   32'(m_ret),             32'(v.exp_mret));
    check({t, " redir s_ret"},   32'(s_ret),             32'(v.exp_sret));
    step();
    check({t, " idle valid"}, 32'(redirect_valid), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int pulses;
    logic [31:0] seen_pc;

    //           valid exc   code   mret  sret  mode  irq      en       pc        epc       evt   chk   cause          mret  sret
    vecs[0]  = '{1'b1, 1'b1, 5'd2,  1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 32'h100, 32'h080, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 5'd2,  1'b0, 1'b0, 2'd3, 4'b1110, 4'b1111, 32'h104, 32'h090, 1'b1, 1'b1, 32'h8000000B, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 5'd2,  1'b0, 1'b0, 2'd3, 4'b1110, 4'b0111, 32'h108, 32'h094, 1'b1, 1'b1, 32'h80000007, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 2'd1, 4'b0011, 4'b0001, 32'h10C, 32'h098, 1'b1, 1'b1, 32'h80000005, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 2'd0, 4'b0010, 4'b0010, 32'h110, 32'h09C, 1'b1, 1'b1, 32'h80000009, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000, 32'h200, 32'h204, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 32'h208, 32'h0A0, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000, 32'h300, 32'h304, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 32'h308, 32'h0A4, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 2'd3, 4'b0000, 4'b0000, 32'h30C, 32'h310, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000, 32'h314, 32'h318, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 2'd3, 4'b0100, 4'b0100, 32'h320, 32'h0A8, 1'b1, 1'b1, 32'h80000007, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b0000, 32'h324, 32'h0AC, 1'b1, 1'b1, 32'h0000000D, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 5'd2,  1'b0, 1'b0, 2'd3, 4'b1111, 4'b1111, 32'h328, 32'h0B0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 2'd3, 4'b1000, 4'b0000, 32'h32C, 32'h0B4, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 2'd1, 4'b0000, 4'b0000, 32'h330, 32'h0B8, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b0};

    rst = 1'b1;
    clear_inputs();
    flush_ack = 1'b0;
    epc       = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step();

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Drain timeout: flush_ack never arrives.
    flush_ack   = 1'b0;
    instr_valid = 1'b1;
    exc_valid   = 1'b1;
    exc_code    = 5'd4;
    instr_pc    = 32'h500;
    step();
    clear_inputs();
    check("to entry flush_req", 32'(flush_req),     32'h1);
    check("to entry sticky",    32'(drain_timeout), 32'h0);
    n = 0;
    while (!exception_pending && n < 100) begin
      step();
      n++;
    end
    check("to commit latency", 32'(n),             32'(DRAIN_MAX));
    check("to commit sticky",  32'(drain_timeout), 32'h1);
    check("to commit m_cause", m_cause,            32'h00000004);
    step();
    step();
    flush_ack = 1'b1;
    run_vec(vecs[0], 100);
    check("to sticky held", 32'(drain_timeout), 32'h1);

    // Busy-ignore: a new exception during DRAIN/COMMIT must not cause a
    // second commit.
    flush_ack   = 1'b0;
    instr_valid = 1'b1;
    exc_valid   = 1'b1;
    exc_code    = 5'd2;
    instr_pc    = 32'h3F0;
    step();
    instr_pc = 32'h400;
    pulses   = 0;
    seen_pc  = '0;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) flush_ack = 1'b1;
      if (redirect_valid) clear_inputs();
      if (exception_pending) begin
        pulses++;
        seen_pc = pc_exc;
      end
      step();
    end
    clear_inputs();
    check("busy pulses", 32'(pulses), 32'h1);
    check("busy pc",     seen_pc,     32'h3F0);

    // Held interrupt restarts the cycle after returning to IDLE.
    flush_ack   = 1'b1;
    instr_valid = 1'b1;
    instr_pc    = 32'h600;
    m_timer     = 1'b1;
    m_tie       = 1'b1;
    step();
    check("irq c1 flush_req", 32'(flush_req),         32'h1);
    step();
    check("irq c2 pending",   32'(exception_pending), 32'h1);
    step();
    check("irq c3 redirect",  32'(redirect_valid),    32'h1);
    step();
    check("irq c4 idle",      32'(flush_req),         32'h0);
    step();
    check("irq c5 flush_req", 32'(flush_req),         32'h1);
    step();
    clear_inputs();
    check("irq c6 pending",   32'(exception_pending), 32'h1);
    check("irq c6 m_cause",   m_cause,                32'h80000007);
    step();
    step();

    // Reset in the middle of DRAIN.
    flush_ack   = 1'b0;
    instr_valid = 1'b1;
    exc_valid   = 1'b1;
    exc_code    = 5'd2;
    instr_pc    = 32'h700;
    step();
    clear_inputs();
    step();
    check("mid flush_req", 32'(flush_req), 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("mid async");
    step();
    check_all_zero("mid edge");
    rst       = 1'b0;
    flush_ack = 1'b1;
    pulses    = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (exception_pending || flush_req) pulses++;
    end
    check("mid no commit", 32'(pulses), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
